get_stream_ctrl: RTL

Parametrised successor to the single-cycle input-accept control of the matrix datapath. It accepts a length-programmed burst of DATA_W-bit words from an upstream valid/ready stream and buffers them in a DEPTH-entry FIFO. It forwards the words to the compute side over a second valid/ready interface and signals completion with a done pulse. Input acceptance is gated by run and suppressed while matw (matrix write) is active.

---
 rtl/get_stream_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/get_stream_ctrl.sv
// Burst input controller: accepts a length-programmed burst from an upstream
// valid/ready stream into a FIFO and forwards it downstream with a done pulse.
// Optional stall statistics counter enabled by defining GET_STREAM_STAT_EN.
module get_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 16,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              matw,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              get_valid,
    input  logic [DATA_W-1:0] get_data,
    output logic              get_ready,
    output logic              get_v,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push_s;
    logic pop_s;
    logic start_ok_s;

    // No bypass: a full FIFO blocks input even when a pop happens this cycle.
    assign get_ready  = (state_q == S_XFER) & run & ~matw &
                        (count_q < CNT_FULL) & (remaining_q != LEN_ZERO);
    assign get_v      = get_valid & get_ready;
    assign push_s     = get_v & ~abort;
    assign out_valid  = (count_q != CNT_ZERO);
    assign pop_s      = out_valid & out_ready & ~abort;
    assign out_data   = mem_q[rd_ptr_q];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign start_ok_s = start & (state_q == S_IDLE) & ~abort;

    // Next-state logic for the burst FSM, FIFO pointers and occupancy.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (abort) begin
            state_d     = S_IDLE;
            remaining_d = LEN_ZERO;
            wr_ptr_d    = PTR_ZERO;
            rd_ptr_d    = PTR_ZERO;
            count_d     = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_d = len;
                        state_d     = (len != LEN_ZERO) ? S_XFER : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_XFER: begin
                    if (push_s) begin
                        remaining_d = remaining_q - LEN_ONE;
                        state_d     = (remaining_q == LEN_ONE) ? S_DRAIN : S_XFER;
                    end else begin
                        state_d = S_XFER;
                    end
                end
                S_DRAIN: begin
                    if (count_q == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= LEN_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= get_data;
        end
    end

`ifdef GET_STREAM_STAT_EN
    localparam logic [STAT_W-1:0] STAT_ZERO = STAT_W'(0);
    localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    logic [STAT_W-1:0] stall_q;

    // Saturating count of cycles where upstream offers data during XFER but is held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= STAT_ZERO;
        end else if (start_ok_s) begin
            stall_q <= STAT_ZERO;
        end else if ((state_q == S_XFER) && get_valid && !get_ready && (stall_q != STAT_MAX)) begin
            stall_q <= stall_q + STAT_ONE;
        end
    end

    assign stall_cnt = stall_q;
`else
    logic unused_start_ok_s;
    assign unused_start_ok_s = start_ok_s;
    assign stall_cnt         = {STAT_W{1'b0}};
`endif

endmodule
